// File: rtl/clut_cache_pkg.sv
// gpu_clut_pkg: shared palette-cache geometry, fill-state encoding and the
// helper that turns a CLUT base plus palette index into a VRAM line tag.
package gpu_clut_pkg;

    localparam int CLUT_LINES       = 16;
    localparam int CLUT_LINE_COLORS = 16;
    localparam int CLUT_BEATS       = 8;
    localparam int CLUT_TAG_W       = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fill_state_e;

    typedef logic [CLUT_TAG_W-1:0] clut_tag_t;

    // X advances in 16-colour units and wraps inside the 64-unit VRAM row,
    // so the carry out of the 6-bit sum must never reach the Y field.
    function automatic clut_tag_t clut_line_tag(input logic [14:0] clutBase,
                                                input logic [7:0]  index);
        logic [5:0] x;
        x = clutBase[5:0] + {2'b00, index[7:4]};
        return {clutBase[14:6], x};
    endfunction

endpackage

// File: rtl/clut_cache_if.sv
// clut_cache_if: burst read port between the palette cache and VRAM.
// Signal names are seen from the cache side (o_ = driven by the cache).
interface clut_cache_if;

    logic        o_memReq;
    logic [14:0] o_memAdr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;

    modport master (
        output o_memReq,
        output o_memAdr,
        input  i_memAck,
        input  i_memDataValid,
        input  i_memData
    );

    modport slave (
        input  o_memReq,
        input  o_memAdr,
        output i_memAck,
        output i_memDataValid,
        output i_memData
    );

endinterface

// File: rtl/clut_cache_fill_ctrl.sv
// clut_fill_ctrl: line-fill FSM of the palette cache. Owns the burst
// handshake, beat counter and stale flag, and tells the cache which RAM pair
// to write and when a line's tag/valid bit may be updated.
module clut_fill_ctrl
    import gpu_clut_pkg::*;
(
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_invalidate,
    input  logic                i_fillReq,
    input  clut_tag_t           i_fillAdr,
    input  logic [3:0]          i_fillSlot,
    clut_cache_if.master        mem,
    output logic                o_ramWe,
    output logic [6:0]          o_ramAdr,
    output logic [31:0]         o_ramData,
    output logic                o_validClr,
    output logic                o_validSet,
    output logic                o_tagSet,
    output logic [3:0]          o_slot,
    output clut_tag_t           o_tag,
    output logic                o_complete
);

    localparam int BEAT_W = $clog2(CLUT_BEATS);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic              r_stale;
    clut_tag_t         r_adr;
    logic [3:0]        r_slot;

    logic              w_beatValid;
    logic              w_lastBeat;

    assign w_beatValid = (r_state == ST_DATA) && mem.i_memDataValid;
    assign w_lastBeat  = w_beatValid && (r_beat == BEAT_W'(CLUT_BEATS - 1));

    // Fill sequencing: latch the line on start, wait for the ack, count the
    // beats, and remember any invalidate seen while the burst was in flight.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_stale <= 1'b0;
            r_adr   <= '0;
            r_slot  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_fillReq) begin
                        r_adr   <= i_fillAdr;
                        r_slot  <= i_fillSlot;
                        r_stale <= 1'b0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_invalidate) begin
                        r_stale <= 1'b1;
                    end
                    if (mem.i_memAck) begin
                        r_beat  <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_invalidate) begin
                        r_stale <= 1'b1;
                    end
                    if (w_beatValid) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_lastBeat) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.o_memReq = (r_state == ST_REQ);
    assign mem.o_memAdr = r_adr;

    assign o_ramWe    = w_beatValid;
    assign o_ramAdr   = {r_slot, r_beat};
    assign o_ramData  = mem.i_memData;

    // The slot is cleared in the start cycle, before r_slot has been loaded.
    assign o_validClr = (r_state == ST_IDLE) && i_fillReq;
    assign o_slot     = (r_state == ST_IDLE) ? i_fillSlot : r_slot;
    assign o_tagSet   = w_lastBeat;
    assign o_validSet = w_lastBeat && !r_stale && !i_invalidate;
    assign o_tag      = r_adr;
    assign o_complete = (r_state == ST_DONE);

endmodule

// File: rtl/clut_cache.sv
// clut_cache: 256-entry palette cache organised as 16 tagged lines of 16
// colours. Hit/miss is combinational, colour data is registered one cycle
// later, and misses are refilled from VRAM by clut_fill_ctrl.
// Optional feature macro: CLUT_CACHE_STATS_EN adds saturating hit/miss
// counters on o_hitCount / o_missCount.
module clut_cache
    import gpu_clut_pkg::*;
(
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_pause,
    input  logic                i_invalidate,
    input  logic [14:0]         GPU_REG_CLUT,
    input  logic                requDataClut_c1,
    input  logic [7:0]          indexPal,
    output logic                ClutHit_c1,
    output logic                ClutMiss_c1,
    output logic [15:0]         dataClut_c2,
    input  logic                requClutCacheUpdate,
    input  logic [14:0]         adrClutCacheUpdate,
    output logic                updateClutCacheComplete,
    clut_cache_if.master        mem
`ifdef CLUT_CACHE_STATS_EN
    ,
    output logic [15:0]         o_hitCount,
    output logic [15:0]         o_missCount
`endif
);

    logic [15:0]           r_ram [CLUT_LINES*CLUT_LINE_COLORS];
    logic [CLUT_LINES-1:0] r_valid;
    clut_tag_t             r_tag [CLUT_LINES];
    logic [15:0]           r_dataC2;

    logic [3:0]            w_slot;
    clut_tag_t             w_expTag;
    logic                  w_hit;
    logic                  w_miss;

    logic                  w_ramWe;
    logic [6:0]            w_ramAdr;
    logic [31:0]           w_ramData;
    logic                  w_validClr;
    logic                  w_validSet;
    logic                  w_tagSet;
    logic [3:0]            w_fillSlot;
    clut_tag_t             w_fillTag;

    assign w_slot   = indexPal[7:4];
    assign w_expTag = clut_line_tag(GPU_REG_CLUT, indexPal);
    assign w_hit    = requDataClut_c1 && r_valid[w_slot] && (r_tag[w_slot] == w_expTag);
    assign w_miss   = requDataClut_c1 && !w_hit;

    assign ClutHit_c1  = w_hit;
    assign ClutMiss_c1 = w_miss;
    assign dataClut_c2 = r_dataC2;

    clut_fill_ctrl u_fill (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_invalidate (i_invalidate),
        .i_fillReq    (requClutCacheUpdate),
        .i_fillAdr    (adrClutCacheUpdate),
        .i_fillSlot   (w_slot),
        .mem          (mem),
        .o_ramWe      (w_ramWe),
        .o_ramAdr     (w_ramAdr),
        .o_ramData    (w_ramData),
        .o_validClr   (w_validClr),
        .o_validSet   (w_validSet),
        .o_tagSet     (w_tagSet),
        .o_slot       (w_fillSlot),
        .o_tag        (w_fillTag),
        .o_complete   (updateClutCacheComplete)
    );

    // Colour RAM: each VRAM beat carries two colours, lower index in [15:0].
    always_ff @(posedge clk) begin
        if (w_ramWe) begin
            r_ram[{w_ramAdr, 1'b0}] <= w_ramData[15:0];
            r_ram[{w_ramAdr, 1'b1}] <= w_ramData[31:16];
        end
    end

    // c2 colour register: follows the looked-up entry unless the pipe is paused.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_dataC2 <= '0;
        end else if (!i_pause) begin
            r_dataC2 <= r_ram[indexPal];
        end
    end

    // Line bookkeeping; a global invalidate overrides a same-cycle valid set.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int i = 0; i < CLUT_LINES; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_validClr) begin
                r_valid[w_fillSlot] <= 1'b0;
            end
            if (w_tagSet) begin
                r_tag[w_fillSlot] <= w_fillTag;
            end
            if (w_validSet) begin
                r_valid[w_fillSlot] <= 1'b1;
            end
            if (i_invalidate) begin
                r_valid <= '0;
            end
        end
    end

`ifdef CLUT_CACHE_STATS_EN
    logic [15:0] r_hitCount;
    logic [15:0] r_missCount;

    // Saturating lookup statistics, frozen while the pipe is paused.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else if (!i_pause) begin
            if (w_hit && (r_hitCount != 16'hFFFF)) begin
                r_hitCount <= r_hitCount + 16'd1;
            end
            if (w_miss && (r_missCount != 16'hFFFF)) begin
                r_missCount <= r_missCount + 16'd1;
            end
        end
    end

    assign o_hitCount  = r_hitCount;
    assign o_missCount = r_missCount;
`endif

endmodule

// File: tb/tb_clut_cache.sv
// tb_clut_cache: scoreboard bench for clut_cache. The driver plays both the
// pixel pipeline and VRAM, predicts every response from a line-level model
// and queues it against a cycle number; the monitor compares on each
// falling edge.
module tb_clut_cache;

    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_DATA = 2;
    localparam int K_CMPL = 3;
    localparam int K_MREQ = 4;
    localparam int K_MADR = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] expv;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_pause;
    logic        i_invalidate;
    logic [14:0] GPU_REG_CLUT;
    logic        requDataClut_c1;
    logic [7:0]  indexPal;
    logic        ClutHit_c1;
    logic        ClutMiss_c1;
    logic [15:0] dataClut_c2;
    logic        requClutCacheUpdate;
    logic [14:0] adrClutCacheUpdate;
    logic        updateClutCacheComplete;
`ifdef CLUT_CACHE_STATS_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;
`endif

    clut_cache_if memBus ();

    clut_cache u_dut (
        .clk                     (clk),
        .i_rst                   (i_rst),
        .i_pause                 (i_pause),
        .i_invalidate            (i_invalidate),
        .GPU_REG_CLUT            (GPU_REG_CLUT),
        .requDataClut_c1         (requDataClut_c1),
        .indexPal                (indexPal),
        .ClutHit_c1              (ClutHit_c1),
        .ClutMiss_c1             (ClutMiss_c1),
        .dataClut_c2             (dataClut_c2),
        .requClutCacheUpdate     (requClutCacheUpdate),
        .adrClutCacheUpdate      (adrClutCacheUpdate),
        .updateClutCacheComplete (updateClutCacheComplete),
        .mem                     (memBus)
`ifdef CLUT_CACHE_STATS_EN
        ,
        .o_hitCount              (hitCount),
        .o_missCount             (missCount)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: palette lines as plain arrays.
    bit          mValid [16];
    int          mTag   [16];
    logic [15:0] mRam   [256];
    bit          mKnown [256];
    logic [15:0] mData;
    bit          mDataKnown;
    bit          rstNow;

    function automatic int lineOf(input logic [14:0] clut, input logic [7:0] idx);
        int y;
        int x;
        y = int'(clut) / 64;
        x = (int'(clut) % 64 + int'(idx) / 16) % 64;
        return y * 64 + x;
    endfunction

    function automatic bit modelHit(input logic [14:0] clut, input logic [7:0] idx);
        int s;
        s = int'(idx) / 16;
        return mValid[s] && (mTag[s] == lineOf(clut, idx));
    endfunction

    task automatic clearAllValid();
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    endtask

    task automatic push(input int c, input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.expv = v;
        e.name = n;
        sbq.push_back(e);
    endtask

    task automatic expectCtl(input int c, input bit cmpl, input bit mreq);
        push(c, K_CMPL, 32'(cmpl), "complete");
        push(c, K_MREQ, 32'(mreq), "memReq");
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one lookup cycle and queue the predicted hit/miss and c2 data.
    task automatic applyStimulus(input bit req, input logic [14:0] clut,
                                 input logic [7:0] idx, input bit pause);
        bit h;
        requDataClut_c1 = req;
        GPU_REG_CLUT    = clut;
        indexPal        = idx;
        i_pause         = pause;
        h = req && modelHit(clut, idx);
        push(cyc, K_HIT, 32'(h), "hit");
        push(cyc, K_MISS, 32'(req && !h), "miss");
        if (rstNow) begin
            mData      = '0;
            mDataKnown = 1'b1;
        end else if (!pause) begin
            mDataKnown = mKnown[idx];
            mData      = mRam[idx];
        end
        if (mDataKnown) push(cyc + 1, K_DATA, {16'h0, mData}, "data");
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        case (e.kind)
            K_HIT:   act = 32'(ClutHit_c1);
            K_MISS:  act = 32'(ClutMiss_c1);
            K_DATA:  act = {16'h0, dataClut_c2};
            K_CMPL:  act = 32'(updateClutCacheComplete);
            K_MREQ:  act = 32'(memBus.o_memReq);
            K_MADR:  act = {17'h0, memBus.o_memAdr};
            default: act = '0;
        endcase
        total++;
        if (act !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, act, e.expv);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t keep[$];
        keep = {};
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) checkOutput(sbq[i]);
            else if (sbq[i].cyc > cyc) keep.push_back(sbq[i]);
        end
        sbq = keep;
    end

    // One complete miss service with the bench acting as VRAM. Lookups on the
    // filling slot stay active throughout and must miss.
    task automatic fillLine(input logic [14:0] clut, input logic [7:0] idx,
                            input logic [14:0] adr, input int invalBeat,
                            input int rstBeat, input int fixBeat,
                            input logic [31:0] fixData);
        int          slot;
        int          ackWait;
        int          beat;
        int          guard;
        bit          stale;
        bit          isBeat;
        bit          doRst;
        logic [31:0] d;
        slot = int'(idx) / 16;

        applyStimulus(1'b1, clut, idx, 1'b0);
        requClutCacheUpdate = 1'b1;
        adrClutCacheUpdate  = adr;
        expectCtl(cyc, 1'b0, 1'b0);
        mValid[slot] = 1'b0;
        stale = 1'b0;
        tick();
        requClutCacheUpdate = 1'b0;
        adrClutCacheUpdate  = 15'($urandom);

        ackWait = int'($urandom_range(0, 3));
        for (int i = 0; i <= ackWait; i++) begin
            applyStimulus(1'b1, clut, idx, 1'b0);
            expectCtl(cyc, 1'b0, 1'b1);
            push(cyc, K_MADR, {17'h0, adr}, "memAdr");
            memBus.i_memAck       = (i == ackWait);
            memBus.i_memDataValid = 1'($urandom_range(0, 1));
            memBus.i_memData      = $urandom;
            tick();
        end
        memBus.i_memAck = 1'b0;

        beat  = 0;
        guard = 0;
        while (beat < 8 && guard < 200) begin
            guard++;
            isBeat = ($urandom_range(0, 3) != 0);
            doRst  = isBeat && (beat == rstBeat);
            rstNow = doRst;
            applyStimulus(1'b1, clut, idx, 1'b0);
            expectCtl(cyc, 1'b0, 1'b0);
            if (!isBeat) begin
                memBus.i_memDataValid = 1'b0;
                memBus.i_memData      = $urandom;
                tick();
            end else begin
                d = (beat == fixBeat) ? fixData : $urandom;
                memBus.i_memDataValid = 1'b1;
                memBus.i_memData      = d;
                mRam[slot*16 + beat*2]       = d[15:0];
                mRam[slot*16 + beat*2 + 1]   = d[31:16];
                mKnown[slot*16 + beat*2]     = 1'b1;
                mKnown[slot*16 + beat*2 + 1] = 1'b1;
                if (beat == 7) begin
                    mTag[slot]   = int'(adr);
                    mValid[slot] = !stale;
                end
                if (beat == invalBeat) begin
                    i_invalidate = 1'b1;
                    stale = 1'b1;
                    clearAllValid();
                end
                if (doRst) begin
                    i_rst = 1'b1;
                    mKnown[slot*16 + beat*2]     = 1'b0;
                    mKnown[slot*16 + beat*2 + 1] = 1'b0;
                end
                tick();
                i_invalidate = 1'b0;
                if (doRst) begin
                    i_rst  = 1'b0;
                    rstNow = 1'b0;
                    memBus.i_memDataValid = 1'b0;
                    clearAllValid();
                    for (int i = 0; i < 16; i++) mTag[i] = 0;
                    for (int i = 0; i < 4; i++) begin
                        applyStimulus(1'b1, clut, idx, 1'b0);
                        push(cyc, K_MISS, 32'd1, "missAfterRst");
                        expectCtl(cyc, 1'b0, 1'b0);
                        push(cyc, K_MADR, 32'd0, "memAdrAfterRst");
                        tick();
                    end
                    return;
                end
                beat++;
            end
        end
        if (guard >= 200) begin
            bad++;
            $display("[TB] FAIL beatLoop cyc=%0d got=%0d beats want=8", cyc, beat);
        end

        applyStimulus(1'b1, clut, idx, 1'b0);
        expectCtl(cyc, 1'b1, 1'b0);
        memBus.i_memDataValid = 1'b1;
        memBus.i_memData      = $urandom;
        tick();
        applyStimulus(1'b1, clut, idx, 1'b0);
        expectCtl(cyc, 1'b0, 1'b0);
        memBus.i_memData = $urandom;
        tick();
        memBus.i_memDataValid = 1'b0;
    endtask

    logic [14:0] cluts [4];
    logic [15:0] held;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        i_rst = 1'b1; i_pause = 1'b0; i_invalidate = 1'b0;
        GPU_REG_CLUT = '0; requDataClut_c1 = 1'b0; indexPal = '0;
        requClutCacheUpdate = 1'b0; adrClutCacheUpdate = '0;
        memBus.i_memAck = 1'b0; memBus.i_memDataValid = 1'b0; memBus.i_memData = '0;
        for (int i = 0; i < 16; i++) begin mValid[i] = 1'b0; mTag[i] = 0; end
        for (int i = 0; i < 256; i++) begin mKnown[i] = 1'b0; mRam[i] = '0; end
        mDataKnown = 1'b0; mData = '0; rstNow = 1'b1;
        cluts[0] = 15'h0040; cluts[1] = 15'h157F; cluts[2] = 15'h0100; cluts[3] = 15'h7FFF;

        // Reset values
        tick();
        applyStimulus(1'b0, 15'h0, 8'h0, 1'b0);
        expectCtl(cyc + 1, 1'b0, 1'b0);
        push(cyc + 1, K_MADR, 32'd0, "memAdrReset");
        tick();
        i_rst = 1'b0; rstNow = 1'b0;
        applyStimulus(1'b0, 15'h0, 8'h0, 1'b0);
        expectCtl(cyc, 1'b0, 1'b0);
        tick();

        // Cold miss and fill of line 0x0042
        applyStimulus(1'b1, 15'h0040, 8'h23, 1'b0);
        push(cyc, K_MISS, 32'd1, "coldMiss");
        tick();
        fillLine(15'h0040, 8'h23, 15'h0042, -1, -1, 1, 32'hBBBB_AAAA);
        applyStimulus(1'b1, 15'h0040, 8'h23, 1'b0);
        push(cyc, K_HIT, 32'd1, "retryHit");
        tick();
        applyStimulus(1'b1, 15'h0040, 8'h22, 1'b0);
        push(cyc + 1, K_DATA, 32'h0000_AAAA, "dataAAAA");
        tick();

        // X wraps to 0 without touching Y
        applyStimulus(1'b1, 15'h157F, 8'h10, 1'b0);
        tick();
        fillLine(15'h157F, 8'h10, 15'h1540, -1, -1, -1, 32'h0);
        applyStimulus(1'b1, 15'h157F, 8'h10, 1'b0);
        push(cyc, K_HIT, 32'd1, "wrapHit");
        tick();

        // Invalidate during beat 4, then refetch
        fillLine(15'h0040, 8'h35, 15'h0043, 4, -1, -1, 32'h0);
        applyStimulus(1'b1, 15'h0040, 8'h35, 1'b0);
        push(cyc, K_MISS, 32'd1, "staleMiss");
        tick();
        fillLine(15'h0040, 8'h35, 15'h0043, -1, -1, -1, 32'h0);
        applyStimulus(1'b1, 15'h0040, 8'h35, 1'b0);
        push(cyc, K_HIT, 32'd1, "refetchHit");
        tick();

        // Pause holds c2 while the index moves
        held = mRam[8'h35];
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 15'h0040, 8'(8'h30 + i), 1'b1);
            push(cyc + 1, K_DATA, {16'h0, held}, "pauseHold");
            tick();
        end
        applyStimulus(1'b1, 15'h0040, 8'h36, 1'b0);
        tick();

        // Reset during beat 5
        fillLine(15'h0040, 8'h23, 15'h0042, -1, 5, -1, 32'h0);
        applyStimulus(1'b1, 15'h0040, 8'h35, 1'b0);
        push(cyc, K_MISS, 32'd1, "postRstMiss");
        tick();

        // Two lines, then a refill of slot 2 with a different tag
        fillLine(15'h0100, 8'h2A, 15'h0102, -1, -1, -1, 32'h0);
        fillLine(15'h0100, 8'h5C, 15'h0105, -1, -1, -1, 32'h0);
        applyStimulus(1'b1, 15'h0100, 8'h2A, 1'b0);
        push(cyc, K_HIT, 32'd1, "slot2Hit");
        tick();
        applyStimulus(1'b1, 15'h0100, 8'h5C, 1'b0);
        push(cyc, K_HIT, 32'd1, "slot5Hit");
        tick();
        fillLine(15'h0200, 8'h2A, 15'h0202, -1, -1, -1, 32'h0);
        applyStimulus(1'b1, 15'h0100, 8'h2A, 1'b0);
        push(cyc, K_MISS, 32'd1, "oldTagMiss");
        tick();
        applyStimulus(1'b1, 15'h0200, 8'h2A, 1'b0);
        push(cyc, K_HIT, 32'd1, "newTagHit");
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 120; n++) begin
            int          r;
            logic [14:0] c;
            logic [7:0]  ix;
            bit          h;
            r  = int'($urandom_range(0, 9));
            c  = cluts[$urandom_range(0, 3)];
            ix = 8'($urandom);
            if (r == 0) begin
                applyStimulus(1'($urandom_range(0, 1)), c, ix, 1'b0);
                i_invalidate = 1'b1;
                clearAllValid();
                tick();
                i_invalidate = 1'b0;
            end else if (r == 1) begin
                applyStimulus(1'b0, c, ix, 1'b0);
                expectCtl(cyc, 1'b0, 1'b0);
                tick();
            end else begin
                h = modelHit(c, ix);
                applyStimulus(1'b1, c, ix, ($urandom_range(0, 4) == 0));
                tick();
                if (!h) begin
                    fillLine(c, ix, 15'(lineOf(c, ix)),
                             ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1,
                             ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1,
                             -1, 32'h0);
                end
            end
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 15'h0, 8'h0, 1'b0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clut_cache.md
# clut_cache

Palette (CLUT) cache that answers the per-pixel palette lookups issued by the GPU pixel pipeline controller and services its line-fill requests from VRAM. It holds the 256-entry, 16-bit palette as 16 tagged lines of 16 colours. It reports hit or miss in the same cycle as the request and returns colour data one cycle later. On a miss it runs a burst fill FSM against the VRAM read port and signals completion back to the pipeline.

## Interface
Parameters:
- none; all geometry is fixed in the shared package.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_pause  in  1  pipeline pause; freezes the c2 data register.
- i_invalidate  in  1  clears all line valid bits (CLUT VRAM region written).
- GPU_REG_CLUT  in  15  current primitive CLUT base; [14:6] is the line Y, [5:0] is X in 16-colour units.
- requDataClut_c1  in  1  lookup request.
- indexPal  in  8  palette index.
- ClutHit_c1  out  1  combinational hit.
- ClutMiss_c1  out  1  combinational miss.
- dataClut_c2  out  16  colour, registered.
- requClutCacheUpdate  in  1  fill request (level).
- adrClutCacheUpdate  in  15  line address to fill, in 32-byte units.
- updateClutCacheComplete  out  1  one-cycle pulse when the fill is finished.
- o_memReq  out  1  burst read request.
- o_memAdr  out  15  burst line address.
- i_memAck  in  1  request accepted.
- i_memDataValid  in  1  data beat valid.
- i_memData  in  32  beat data; [15:0] is the lower colour index.

## Operation
- Storage:
  - colour RAM of 256x16; entry = {slot[3:0], sub[3:0]}.
  - per slot: valid bit and 15-bit tag.
- Lookup:
  - slot = indexPal[7:4].
  - expTag = {GPU_REG_CLUT[14:6], GPU_REG_CLUT[5:0] + indexPal[7:4]}; the 6-bit sum wraps mod 64.
  - ClutHit_c1 = requDataClut_c1 & valid[slot] & (tag[slot]==expTag).
  - ClutMiss_c1 = requDataClut_c1 & !hit.
  - Both are 0 when there is no request.
- Data: when !i_pause, dataClut_c2 <= RAM[indexPal]. It loads regardless of hit; the consumer ignores it on a miss.
- Fill FSM has four states:
  - IDLE: if requClutCacheUpdate, latch adrClutCacheUpdate as the tag and indexPal[7:4] as fillSlot, clear valid[fillSlot], then go to REQ.
  - REQ: o_memReq=1 and o_memAdr = latched address. On i_memAck go to DATA with beat=0.
  - DATA: each i_memDataValid writes RAM[{fillSlot, beat,0}] = data[15:0] and RAM[{fillSlot, beat,1}] = data[31:16], then beat++. On beat 7, set tag and set valid[fillSlot] (unless stale), then go to DONE.
  - DONE: updateClutCacheComplete=1 for one cycle, then go to IDLE.
- requClutCacheUpdate is ignored outside IDLE. The caller holds indexPal and GPU_REG_CLUT stable from miss until complete.
- Boundary rules:
  - i_invalidate clears every valid bit at once. If asserted during REQ or DATA, it sets a stale flag: the fill finishes, complete still pulses, valid stays 0, and the pipeline re-misses and refetches.
  - i_invalidate together with the final beat: the line stays invalid.
  - i_memDataValid in IDLE, REQ or DONE is ignored.
  - A lookup on a slot being filled is a miss, since its valid bit was cleared at fill start.

## Timing
- Hit/miss: zero latency, combinational from request inputs.
- Data: one cycle after the lookup, held while i_pause.
- Fill: start to complete = 1 (IDLE→REQ) + ack wait + 8 beats + 1 (DONE) cycles minimum. Valid rises on the same edge DONE is entered, so the retried lookup in the cycle after the pulse hits.
- Reset values:
  - all valid=0, tags=0, state IDLE, beat=0, stale=0.
  - o_memReq=0, o_memAdr=0, updateClutCacheComplete=0, dataClut_c2=0.
  - RAM contents are not reset.
- Reset mid-fill aborts immediately and no complete pulse is issued.

## Configuration
- CLUT_CACHE_STATS_EN defined: adds outputs o_hitCount[15:0] and o_missCount[15:0].
  - They count cycles with hit or miss, gated by !i_pause.
  - They saturate at 16'hFFFF and clear on i_rst.
- Undefined: these ports and counters do not exist.

## Structure
- Package gpu_clut_pkg holds:
  - CLUT_LINES=16, CLUT_LINE_COLORS=16, CLUT_BEATS=8 constants;
  - the fill-state enum {IDLE, REQ, DATA, DONE};
  - the tag width of 15.
- One sub-module, clut_fill_ctrl, contains the FSM, beat counter, stale flag and memory handshake. It outputs RAM write enable, address and data, plus the valid-set strobe.

## Test plan
- Cold miss: CLUT=15'h0040, index=8'h23 → miss=1, fill address 15'h0042. After 8 beats with data 32'hBBBB_AAAA at beat 1, complete pulses. The retry hits, and index 8'h22 gives dataClut_c2=16'hAAAA one cycle later.
- Wrap: CLUT X=6'h3F, index=8'h10 → expected tag X=6'h00 with the same Y.
- Invalidate during DATA beat 4 → complete pulses, next lookup misses, and a second fill is requested.
- i_pause held 3 cycles with index changing → dataClut_c2 is unchanged until pause drops.
- i_rst at beat 5 → o_memReq=0, no complete pulse, all lookups miss.
- Two fills to slots 2 and 5 → both hit afterward; refill of slot 2 with a new tag → the old tag misses.
